// File: rtl/lag_pkg.sv
// Shared state encoding and default parameters for the input-lag measurement controller.
package lag_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        CAPTURE,
        EXPIRE
    } lag_state_t;

    localparam int DEF_TICK_DIV      = 270;
    localparam int DEF_COUNT_W       = 20;
    localparam int DEF_TIMEOUT_TICKS = 50000;
    localparam int DEF_DEBOUNCE      = 8;
    localparam int DEF_AVG_LOG2      = 4;

endpackage

// File: rtl/sensor_debounce.sv
// Photo-sensor conditioning: two-flop synchroniser, stability filter and a
// one-cycle pulse on each filtered rising transition.
module sensor_debounce #(
    parameter int DEBOUNCE = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep the two sync stages as two distinct flops.
            sync_q1 <= sensor;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            // Any cycle back at the current level restarts the stability run.
            if (sync_q2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_q2;
                rise       <= sync_q2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lag_measure_ctrl.sv
// Input-lag measurement sequencer: arms on the start trigger, times to the filtered
// sensor rise in prescaled ticks, flags timeouts and keeps last/min/max/average stats.
module lag_measure_ctrl
    import lag_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int COUNT_W       = DEF_COUNT_W,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int DEBOUNCE      = DEF_DEBOUNCE,
    parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               starttrigger,
    input  logic               config_clear,
    input  logic               sensor,
    output logic               sensor_level,
    output logic [COUNT_W-1:0] last_count,
    output logic [COUNT_W-1:0] min_count,
    output logic [COUNT_W-1:0] max_count,
    output logic [COUNT_W-1:0] avg_count,
    output logic [15:0]        sample_count,
    output logic               meas_valid,
    output logic               avg_valid,
    output logic               timeout,
    output logic               busy
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ACC_W   = COUNT_W + AVG_LOG2;
    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] TIMEOUT_CNT = COUNT_W'(TIMEOUT_TICKS);

    lag_state_t           state;
    logic [PRESC_W-1:0]   presc;
    logic [COUNT_W-1:0]   elapsed;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_sum;
    logic [AVG_LOG2-1:0]  blk_idx;
    logic                 sensor_rise;

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .sensor (sensor),
        .level  (sensor_level),
        .rise   (sensor_rise)
    );

    // Running block sum including the sample being captured this cycle.
    assign acc_sum = acc + ACC_W'(elapsed);
    assign busy    = (state == MEASURE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            presc        <= '0;
            elapsed      <= '0;
            acc          <= '0;
            blk_idx      <= '0;
            last_count   <= '0;
            min_count    <= '1;
            max_count    <= '0;
            avg_count    <= '0;
            sample_count <= '0;
            meas_valid   <= 1'b0;
            avg_valid    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle; the branches below only ever raise them.
            meas_valid <= 1'b0;
            avg_valid  <= 1'b0;
            if (config_clear) begin
                state        <= IDLE;
                acc          <= '0;
                blk_idx      <= '0;
                last_count   <= '0;
                min_count    <= '1;
                max_count    <= '0;
                avg_count    <= '0;
                sample_count <= '0;
                timeout      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (starttrigger) begin
                            state   <= MEASURE;
                            presc   <= '0;
                            elapsed <= '0;
                        end
                    end
                    MEASURE: begin
                        if (starttrigger) begin
                            presc   <= '0;
                            elapsed <= '0;
                        end else if (sensor_rise) begin
                            state      <= CAPTURE;
                            last_count <= elapsed;
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            if (elapsed < min_count) min_count <= elapsed;
                            if (elapsed > max_count) max_count <= elapsed;
                            if (sample_count != 16'hFFFF) sample_count <= sample_count + 16'd1;
                            if (blk_idx == '1) begin
                                avg_count <= acc_sum[AVG_LOG2 +: COUNT_W];
                                avg_valid <= 1'b1;
                                acc       <= '0;
                                blk_idx   <= '0;
                            end else begin
                                acc     <= acc_sum;
                                blk_idx <= blk_idx + AVG_LOG2'(1);
                            end
                        end else if (elapsed == TIMEOUT_CNT) begin
                            state   <= EXPIRE;
                            timeout <= 1'b1;
                        end else if (presc == PRESC_LAST) begin
                            presc   <= '0;
                            elapsed <= elapsed + COUNT_W'(1);
                        end else begin
                            presc <= presc + PRESC_W'(1);
                        end
                    end
                    // Both result states last one cycle; a trigger seen here is dropped.
                    CAPTURE, EXPIRE: state <= IDLE;
                    default:         state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lag_measure_ctrl.sv
// Randomised and directed bench for lag_measure_ctrl, checked every cycle against
// a timestamp-based reference model of the measurement rules.
module tb_lag_measure_ctrl;

    localparam int    TICK_DIV = 4;
    localparam int    COUNT_W  = 20;
    localparam int    TIMEOUT  = 20;
    localparam int    DEBOUNCE = 2;
    localparam int    AVG_LOG2 = 2;
    localparam int    AVG_N    = 1 << AVG_LOG2;
    localparam longint MIN_INIT = (64'd1 << COUNT_W) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_DONE  = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic               starttrigger;
    logic               config_clear;
    logic               sensor;
    logic               sensor_level;
    logic [COUNT_W-1:0] last_count;
    logic [COUNT_W-1:0] min_count;
    logic [COUNT_W-1:0] max_count;
    logic [COUNT_W-1:0] avg_count;
    logic [15:0]        sample_count;
    logic               meas_valid;
    logic               avg_valid;
    logic               timeout;
    logic               busy;

    lag_measure_ctrl #(
        .TICK_DIV      (TICK_DIV),
        .COUNT_W       (COUNT_W),
        .TIMEOUT_TICKS (TIMEOUT),
        .DEBOUNCE      (DEBOUNCE),
        .AVG_LOG2      (AVG_LOG2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .starttrigger (starttrigger),
        .config_clear (config_clear),
        .sensor       (sensor),
        .sensor_level (sensor_level),
        .last_count   (last_count),
        .min_count    (min_count),
        .max_count    (max_count),
        .avg_count    (avg_count),
        .sample_count (sample_count),
        .meas_valid   (meas_valid),
        .avg_valid    (avg_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int mv_seen  = 0;
    int av_seen  = 0;
    bit sens_drv = 1'b0;

    // Reference model: measurement phase with start timestamp, sensor history, stats.
    int     cyc = 0;
    int     m_phase, m_start;
    bit     m_s1, m_s2, m_lvl, m_rise;
    int     m_run;
    longint m_last, m_min, m_max, m_avg, m_cnt;
    bit     m_to, m_mv, m_av;
    longint m_blk[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        m_last = 0; m_min = MIN_INIT; m_max = 0; m_avg = 0; m_cnt = 0; m_to = 0;
        m_blk.delete();
    endtask

    task automatic model_reset();
        clear_stats();
        m_phase = P_IDLE; m_start = 0; m_mv = 0; m_av = 0;
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_run = 0;
    endtask

    task automatic record(input longint e);
        longint sum;
        m_last = e;
        if (e < m_min) m_min = e;
        if (e > m_max) m_max = e;
        if (m_cnt < 65535) m_cnt++;
        m_to = 0;
        m_mv = 1;
        m_blk.push_back(e);
        if (m_blk.size() == AVG_N) begin
            sum = 0;
            foreach (m_blk[k]) sum += m_blk[k];
            m_avg = sum / AVG_N;
            m_av  = 1;
            m_blk.delete();
        end
    endtask

    // Advance the model across one clock edge, given the inputs held in the cycle before it.
    task automatic model_step(input bit trig, input bit clr, input bit sens);
        longint e;
        bit     new_rise;
        cyc++;
        m_mv = 0;
        m_av = 0;
        e = longint'((cyc - 1 - m_start) / TICK_DIV);
        if (clr) begin
            clear_stats();
            m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (trig) begin m_phase = P_ARMED; m_start = cyc; end
        end else if (m_phase == P_ARMED) begin
            if (trig) m_start = cyc;
            else if (m_rise) begin record(e); m_phase = P_DONE; end
            else if (e == TIMEOUT) begin m_to = 1; m_phase = P_DONE; end
        end else begin
            m_phase = P_IDLE;
        end
        new_rise = 0;
        if (m_s2 != m_lvl) begin
            m_run++;
            if (m_run == DEBOUNCE) begin m_lvl = m_s2; new_rise = m_lvl; m_run = 0; end
        end else begin
            m_run = 0;
        end
        m_rise = new_rise;
        m_s2   = m_s1;
        m_s1   = sens;
    endtask

    task automatic compare_all();
        check($sformatf("sensor_level@%0d", cyc), sensor_level, m_lvl);
        check($sformatf("busy@%0d", cyc), busy, m_phase == P_ARMED);
        check($sformatf("meas_valid@%0d", cyc), meas_valid, m_mv);
        check($sformatf("avg_valid@%0d", cyc), avg_valid, m_av);
        check($sformatf("timeout@%0d", cyc), timeout, m_to);
        check($sformatf("last_count@%0d", cyc), last_count, m_last);
        check($sformatf("min_count@%0d", cyc), min_count, m_min);
        check($sformatf("max_count@%0d", cyc), max_count, m_max);
        check($sformatf("avg_count@%0d", cyc), avg_count, m_avg);
        check($sformatf("sample_count@%0d", cyc), sample_count, m_cnt);
        if (meas_valid === 1'b1) mv_seen++;
        if (avg_valid === 1'b1) av_seen++;
    endtask

    task automatic tick(input bit trig, input bit clr);
        starttrigger = trig;
        config_clear = clr;
        sensor       = sens_drv;
        @(posedge clock);
        model_step(trig, clr, sens_drv);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    // Trigger, then raise the sensor so the filtered rise lands 4*ticks+extra cycles after acceptance.
    task automatic measure(input int ticks, input int extra);
        int n;
        n = TICK_DIV * ticks + extra;
        tick(1'b1, 1'b0);
        idle(n - 4);
        sens_drv = 1'b1;
        idle(6);
        sens_drv = 1'b0;
        idle(8);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_last"}, last_count, 0);
        check({pfx, "_min"}, min_count, MIN_INIT);
        check({pfx, "_max"}, max_count, 0);
        check({pfx, "_avg"}, avg_count, 0);
        check({pfx, "_samples"}, sample_count, 0);
        check({pfx, "_meas_valid"}, meas_valid, 0);
        check({pfx, "_avg_valid"}, avg_valid, 0);
        check({pfx, "_timeout"}, timeout, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_level"}, sensor_level, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mv0, av0, hold;
        reset = 1'b1; starttrigger = 1'b0; config_clear = 1'b0; sensor = 1'b0;
        model_reset();
        #12;
        check_reset_values("por");
        @(posedge clock);
        #1 reset = 1'b0;
        idle(4);

        // 1: single measurement of 40 cycles -> 10 ticks
        mv0 = mv_seen;
        measure(10, 0);
        check("t1_last", last_count, 10);
        check("t1_min", min_count, 10);
        check("t1_max", max_count, 10);
        check("t1_samples", sample_count, 1);
        check("t1_pulses", mv_seen - mv0, 1);
        check("t1_timeout", timeout, 0);

        // 2: block of four samples from a cleared state
        tick(1'b0, 1'b1);
        av0 = av_seen;
        measure(10, 1);
        measure(12, 3);
        measure(7, 2);
        check("t2_no_avg_yet", av_seen - av0, 0);
        measure(13, 0);
        check("t2_min", min_count, 7);
        check("t2_max", max_count, 13);
        check("t2_avg", avg_count, 10);
        check("t2_avg_pulses", av_seen - av0, 1);

        // 3: timeout, then a valid sample clears it
        tick(1'b1, 1'b0);
        idle(TICK_DIV * TIMEOUT + 6);
        check("t3_timeout", timeout, 1);
        check("t3_samples", sample_count, 4);
        check("t3_last", last_count, 13);
        measure(6, 2);
        check("t3_cleared", timeout, 0);
        check("t3_last2", last_count, 6);

        // 4: retrigger 20 cycles into MEASURE, rise 12 cycles after the restart
        mv0 = mv_seen;
        tick(1'b1, 1'b0);
        idle(19);
        tick(1'b1, 1'b0);
        idle(12 - 4);
        sens_drv = 1'b1;
        idle(6);
        sens_drv = 1'b0;
        idle(8);
        check("t4_last", last_count, 3);
        check("t4_pulses", mv_seen - mv0, 1);

        // 5: config_clear in the same cycle the filtered rise is presented
        tick(1'b1, 1'b0);
        idle(6);
        sens_drv = 1'b1;
        idle(4);
        tick(1'b0, 1'b1);
        check("t5_meas_valid", meas_valid, 0);
        check("t5_level", sensor_level, 1);
        check("t5_min", min_count, MIN_INIT);
        check("t5_max", max_count, 0);
        check("t5_samples", sample_count, 0);
        check("t5_busy", busy, 0);
        sens_drv = 1'b0;
        idle(8);

        // 6: glitch in MEASURE is filtered, then async reset mid-measurement
        measure(9, 1);
        mv0 = mv_seen;
        tick(1'b1, 1'b0);
        idle(8);
        sens_drv = 1'b1;
        tick(1'b0, 1'b0);
        sens_drv = 1'b0;
        idle(10);
        check("t6_glitch_pulses", mv_seen - mv0, 0);
        check("t6_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_reset_values("t6_rst");
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        idle(3);
        check("t6_idle_after", busy, 0);

        // Randomised traffic: triggers, clears, glitches and arbitrary sensor runs
        hold = 0;
        for (int i = 0; i < 2500; i++) begin
            if (hold == 0) begin
                sens_drv = ~sens_drv;
                hold = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 60));
            end
            hold--;
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 399) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
